// File: rtl/vga_pixel_writer_if.sv
// Packed pixel handshake bus between the draw-source mux (master) and the pixel writer (slave).
interface vga_pixel_writer_if;
    logic [17:0] in_word;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_word, output in_valid, input in_ready);
    modport slave  (input in_word, input in_valid, output in_ready);
endinterface

// File: rtl/vga_pixel_writer.sv
// Buffers packed pixel words in a small FIFO, range-checks them and drives the VGA
// adapter one pixel per clock; out-of-range pixels are dropped and counted.
module vga_pixel_writer #(
    parameter int DEPTH = 4,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic                clk,
    input  logic                resetn,
    vga_pixel_writer_if.slave   in_bus,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [2:0]          vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic [7:0]          drop_count
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [8:0]  X_LIM    = X_MAX[8:0];
    localparam logic [7:0]  Y_LIM    = Y_MAX[7:0];

    logic [17:0]   mem_q [DEPTH];
    logic [17:0]   mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          plot_q, plot_d;
    logic [7:0]    drop_q, drop_d;

    logic          full, push, pop, in_range;
    logic [17:0]   head;

    always_comb begin
        full            = (count_q == FULL_CNT);
        in_bus.in_ready = resetn & ~full;
        push            = in_bus.in_valid & in_bus.in_ready;
        pop             = (count_q != '0);
        head            = mem_q[rd_ptr_q];
        in_range        = ({1'b0, head[17:10]} < X_LIM) && ({1'b0, head[9:3]} < Y_LIM);

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        drop_d   = drop_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_bus.in_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (in_range) begin
                x_d      = head[17:10];
                y_d      = head[9:3];
                colour_d = head[2:0];
                plot_d   = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end

        // Push and pop in the same cycle leave the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_q;
    assign vga_plot   = plot_q;
    assign drop_count = drop_q;
    assign busy       = (count_q != '0) | plot_q;
endmodule

// File: tb/tb_vga_pixel_writer.sv
// Bench for vga_pixel_writer: constant-expectation vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_vga_pixel_writer;
    localparam int DEPTH = 4;

    logic       clk;
    logic       resetn;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic [7:0] drop_count;

    vga_pixel_writer_if bus ();

    vga_pixel_writer #(.DEPTH(DEPTH), .X_MAX(160), .Y_MAX(120)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_bus     (bus),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted words queue plus the visible adapter outputs.
    int q[$];
    int m_x, m_y, m_c, m_plot, m_drop;

    function automatic logic [17:0] pack(input int x, input int y, input int c);
        logic [7:0] xx;
        logic [6:0] yy;
        logic [2:0] cc;
        xx = x[7:0];
        yy = y[6:0];
        cc = c[2:0];
        return {xx, yy, cc};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check ready, advance the model across the edge, check outputs.
    task automatic step(input logic rst_n, input logic v, input logic [17:0] w);
        int exp_ready, hw, hx, hy;
        resetn       = rst_n;
        bus.in_valid = v;
        bus.in_word  = w;
        #1;
        exp_ready = (rst_n && q.size() < DEPTH) ? 1 : 0;
        chk("in_ready", int'(bus.in_ready), exp_ready);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_x = 0; m_y = 0; m_c = 0; m_plot = 0; m_drop = 0;
        end else begin
            m_plot = 0;
            if (q.size() > 0) begin
                hw = q.pop_front();
                hx = hw / 1024;
                hy = (hw / 8) % 128;
                if (hx < 160 && hy < 120) begin
                    m_x = hx; m_y = hy; m_c = hw % 8; m_plot = 1;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            if (v && exp_ready == 1) q.push_back(int'(w));
        end
        #1;
        chk("vga_plot", int'(vga_plot), m_plot);
        chk("vga_x", int'(vga_x), m_x);
        chk("vga_y", int'(vga_y), m_y);
        chk("vga_colour", int'(vga_colour), m_c);
        chk("drop_count", int'(drop_count), m_drop);
        chk("busy", int'(busy), (q.size() != 0 || m_plot != 0) ? 1 : 0);
    endtask

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [17:0] word;
        int          plot, x, y, c, drop;
    } vec_t;

    vec_t vecs[$];
    int   plots_seen;

    initial begin
        resetn = 1'b0; bus.in_valid = 1'b0; bus.in_word = '0;
        m_x = 0; m_y = 0; m_c = 0; m_plot = 0; m_drop = 0;

        // Hand-computed expectations, independent of the model.
        vecs.push_back('{1'b0, 1'b0, 18'h0,             0,   0,   0, 0, 0});
        vecs.push_back('{1'b1, 1'b1, 18'h01455,         0,   0,   0, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 18'h0,             1,   5,  10, 5, 0});
        vecs.push_back('{1'b1, 1'b0, 18'h0,             0,   5,  10, 5, 0});
        vecs.push_back('{1'b1, 1'b1, pack(160, 0, 1),   0,   5,  10, 5, 0});
        vecs.push_back('{1'b1, 1'b1, pack(0, 120, 2),   0,   5,  10, 5, 1});
        vecs.push_back('{1'b1, 1'b1, pack(159, 119, 7), 0,   5,  10, 5, 2});
        vecs.push_back('{1'b1, 1'b0, 18'h0,             1, 159, 119, 7, 2});
        vecs.push_back('{1'b1, 1'b0, 18'h0,             0, 159, 119, 7, 2});
        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].valid, vecs[i].word);
            chk("tbl_plot", int'(vga_plot), vecs[i].plot);
            chk("tbl_x", int'(vga_x), vecs[i].x);
            chk("tbl_y", int'(vga_y), vecs[i].y);
            chk("tbl_colour", int'(vga_colour), vecs[i].c);
            chk("tbl_drop", int'(drop_count), vecs[i].drop);
        end
        chk("tbl_busy_idle", int'(busy), 0);

        // Eight back-to-back in-range words: ready stays high, eight consecutive plots.
        plots_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1'b1, 1'b1, pack(10 + i, 20 + i, i));
            else       step(1'b1, 1'b0, 18'h0);
            if (i >= 1 && i <= 8) begin
                chk("burst_plot", int'(vga_plot), 1);
                chk("burst_x", int'(vga_x), 9 + i);
            end
            plots_seen += int'(vga_plot);
        end
        chk("burst_count", plots_seen, 8);
        chk("burst_drop", int'(drop_count), 2);

        // Reset the drop counter, then push DEPTH+2 words back to back; none lost.
        step(1'b0, 1'b0, 18'h0);
        plots_seen = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            step(1'b1, (i < DEPTH + 2), pack(100 + i, i, 3));
            plots_seen += int'(vga_plot);
        end
        chk("stall_plots", plots_seen, DEPTH + 2);

        // Reset mid-stream before any plot: word discarded, outputs cleared.
        step(1'b1, 1'b1, pack(3, 3, 3));
        step(1'b0, 1'b1, pack(4, 4, 4));
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_x", int'(vga_x), 0);
        step(1'b1, 1'b0, 18'h0);
        chk("rst_after_plot", int'(vga_plot), 0);
        chk("rst_after_busy", int'(busy), 0);

        // 300 out-of-range words: drop count saturates, never plots.
        plots_seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b1, pack(160 + $urandom_range(0, 95), $urandom_range(0, 127), $urandom_range(0, 7)));
            else            step(1'b1, 1'b1, pack($urandom_range(0, 159), 120 + $urandom_range(0, 7), $urandom_range(0, 7)));
            plots_seen += int'(vga_plot);
        end
        step(1'b1, 1'b0, 18'h0);
        step(1'b1, 1'b0, 18'h0);
        chk("sat_drop", int'(drop_count), 255);
        chk("sat_noplot", plots_seen, 0);

        // Random traffic with occasional resets.
        step(1'b0, 1'b0, 18'h0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                 pack($urandom_range(0, 200), $urandom_range(0, 127), $urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
